// File: rtl/fret_judge.sv
// fret_judge: synchronises and debounces three fret buttons and judges each debounced press
// against its lane's bottom-row note, emitting registered hit/miss/skip counts.
module fret_judge #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       button0,
  input  logic       button1,
  input  logic       button2,
  input  logic       led0,
  input  logic       led8,
  input  logic       led16,
  input  logic       shift_tick,
  output logic [2:0] held,
  output logic [1:0] hit_cnt,
  output logic [1:0] miss_cnt,
  output logic [1:0] skip_cnt
);
  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  logic [2:0] raw, led, sync1_q, sync_q, held_q, held_d, cons_q, cons_d, led_q;
  logic [2:0] diff, done, press, eff, hit, miss, skip;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];
  logic [1:0] hit_q, miss_q, skip_q;

  function automatic logic [1:0] popcount(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  assign raw = {button2, button1, button0};
  assign led = {led16, led8, led0};
  assign diff = sync_q ^ held_q;
  always_comb begin
    done = '0;
    for (int i = 0; i < 3; i++) begin
      done[i] = diff[i] && (cnt_q[i] == LAST);
      cnt_d[i] = (diff[i] && !done[i]) ? cnt_q[i] + DB_W'(1) : '0;
    end
  end
  assign held_d = held_q ^ done;
  assign press = done & sync_q;
  // a tick brings a fresh note row, so earlier hits no longer protect this lane
  assign eff = cons_q & ~{3{shift_tick}};
  assign hit = press & led & ~eff;
  assign miss = press & ~hit;
  assign skip = {3{shift_tick}} & led_q & ~cons_q;
  assign cons_d = eff | hit;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync_q <= '0;
      held_q <= '0;
      cons_q <= '0;
      led_q <= '0;
      cnt_q <= '{default: '0};
      hit_q <= '0;
      miss_q <= '0;
      skip_q <= '0;
    end else begin
      sync1_q <= raw;
      sync_q <= sync1_q;
      held_q <= held_d;
      cons_q <= cons_d;
      led_q <= led;
      cnt_q <= cnt_d;
      hit_q <= popcount(hit);
      miss_q <= popcount(miss);
      skip_q <= popcount(skip);
    end
  end

  assign held = held_q;
  assign hit_cnt = hit_q;
  assign miss_cnt = miss_q;
  assign skip_cnt = skip_q;
endmodule

// File: tb/tb_fret_judge.sv
// tb_fret_judge: random buttons, notes and ticks checked against a window-based reference model.
module tb_fret_judge;
  localparam int DC = 4;
  logic sysclk = 0;
  logic reset = 1;
  logic [2:0] btn = '0;
  logic [2:0] led = '0;
  logic shift_tick = 0;
  logic [2:0] held;
  logic [1:0] hit_cnt, miss_cnt, skip_cnt;
  int n_checks = 0;
  int n_fail = 0;

  fret_judge #(.DEBOUNCE_CYCLES(DC), .DB_W(3)) dut (
    .sysclk(sysclk), .reset(reset),
    .button0(btn[0]), .button1(btn[1]), .button2(btn[2]),
    .led0(led[0]), .led8(led[1]), .led16(led[2]),
    .shift_tick(shift_tick),
    .held(held), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .skip_cnt(skip_cnt)
  );

  always #5 sysclk = ~sysclk;

  // model: held flips once the last DC synchronised samples all disagree with it
  logic [2:0] m_s1, m_s2, m_held, m_cons, m_ledq;
  logic [2:0] m_hist [DC];
  int e_hit, e_miss, e_skip;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_held = '0; m_cons = '0; m_ledq = '0;
    for (int j = 0; j < DC; j++) m_hist[j] = '0;
    e_hit = 0; e_miss = 0; e_skip = 0;
  endtask

  task automatic model_step();
    logic [2:0] flip, press, eff, hit, miss, skip;
    for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j - 1];
    m_hist[0] = m_s2;
    flip = '1;
    for (int j = 0; j < DC; j++) flip &= m_hist[j] ^ m_held;
    press = flip & m_s2;
    eff = shift_tick ? 3'b000 : m_cons;
    hit = press & led & ~eff;
    miss = press & ~hit;
    skip = shift_tick ? (m_ledq & ~m_cons) : 3'b000;
    e_hit = $countones(hit);
    e_miss = $countones(miss);
    e_skip = $countones(skip);
    m_cons = eff | hit;
    m_ledq = led;
    m_held = m_held ^ flip;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_held"}, 8'(held), 8'(m_held));
    check({tag, "_hit"}, 8'(hit_cnt), 8'(e_hit));
    check({tag, "_miss"}, 8'(miss_cnt), 8'(e_miss));
    check({tag, "_skip"}, 8'(skip_cnt), 8'(e_skip));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge sysclk);
    #1 check_all("reset");
    @(negedge sysclk);
    reset = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge sysclk);
      if (!reset && $urandom_range(0, 399) == 0) begin
        reset = 1;
        model_reset();
        #1 check_all("async_rst");
      end else if (reset && $urandom_range(0, 2) == 0) begin
        reset = 0;
      end
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      shift_tick = ($urandom_range(0, 19) == 0);
      if (shift_tick) led = 3'($urandom_range(0, 7));
      @(posedge sysclk);
      if (reset) model_reset();
      else model_step();
      #1 check_all("run");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
